// File: rtl/fib_access_scheduler.sv
// fib_access_scheduler
//   Sequences the FIB valid-bit table and the single shared hash unit between
//   the insert path (prefixes of arriving data packets) and the longest-prefix-
//   match lookup path (outgoing interests). Clears the whole table after reset
//   and on request, and runs the LPM loop by walking the prefix length down.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   ins_req/ins_prefix/ins_len    insert request (level) and its data
//   ins_ack                       insert done, 1-cycle pulse
//   lkp_req/lkp_prefix/lkp_len    lookup request (level), prefix, start length
//   lkp_done                      lookup done, 1-cycle pulse
//   lkp_hit/lkp_len_out/lkp_prefix_out  result of the last completed lookup
//   clr_req, clr_busy             clear request (level), clear in progress
//   hash_prefix/hash_len          hash unit inputs
//   hash_value                    hash unit output, valid HASH_LAT cycles later
//   tbl_addr/tbl_we/tbl_wdata     table port, address is {len, hash}
//   tbl_rdata                     read data, valid one cycle after the address
//
// State table
//   state   | meaning
//   CLEAR   | writing 0 to every table address, 0 upward
//   IDLE    | waiting; clear request first, then round-robin grant
//   HASH    | hash inputs held for HASH_LAT cycles, result taken in the last
//   WRITE   | insert writes valid bit, ins_ack pulses
//   READ    | lookup presents {cur_len, hash} for read
//   CHECK   | read data evaluated: hit, shorter probe, or miss
//   DONE    | lkp_done pulses with the result
module fib_access_scheduler #(
  parameter int PREFIX_W = 64,
  parameter int LEN_W    = 6,
  parameter int HASH_W   = 10,
  parameter int HASH_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ins_req,
  input  logic [PREFIX_W-1:0]       ins_prefix,
  input  logic [LEN_W-1:0]          ins_len,
  output logic                      ins_ack,
  input  logic                      lkp_req,
  input  logic [PREFIX_W-1:0]       lkp_prefix,
  input  logic [LEN_W-1:0]          lkp_len,
  output logic                      lkp_done,
  output logic                      lkp_hit,
  output logic [LEN_W-1:0]          lkp_len_out,
  output logic [PREFIX_W-1:0]       lkp_prefix_out,
  input  logic                      clr_req,
  output logic                      clr_busy,
  output logic [PREFIX_W-1:0]       hash_prefix,
  output logic [LEN_W-1:0]          hash_len,
  input  logic [HASH_W-1:0]         hash_value,
  output logic [LEN_W+HASH_W-1:0]   tbl_addr,
  output logic                      tbl_we,
  output logic                      tbl_wdata,
  input  logic                      tbl_rdata
);

  localparam int ADDR_W = LEN_W + HASH_W;
  // Clear counter is one bit wider so that "all addresses written" is a
  // distinct value rather than a wrap back to 0.
  localparam logic [ADDR_W:0] CLR_END   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CLR_ONE   = (ADDR_W+1)'(1);
  localparam logic [2:0]      HCNT_LAST = 3'(HASH_LAT - 1);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_HASH, S_WRITE, S_READ, S_CHECK, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     clr_cnt_q, clr_cnt_d;
  logic [2:0]          hcnt_q, hcnt_d;
  logic                is_lkp_q, is_lkp_d;
  logic                rr_q, rr_d;          // 1: lookup wins the next tie
  logic [PREFIX_W-1:0] pfx_q, pfx_d;
  logic [LEN_W-1:0]    cur_len_q, cur_len_d;

  logic                ins_ack_q, ins_ack_d;
  logic                lkp_done_q, lkp_done_d;
  logic                lkp_hit_q, lkp_hit_d;
  logic [LEN_W-1:0]    lkp_len_out_q, lkp_len_out_d;
  logic [PREFIX_W-1:0] lkp_prefix_out_q, lkp_prefix_out_d;
  logic                clr_busy_q, clr_busy_d;
  logic [PREFIX_W-1:0] hash_prefix_q, hash_prefix_d;
  logic [LEN_W-1:0]    hash_len_q, hash_len_d;
  logic [ADDR_W-1:0]   tbl_addr_q, tbl_addr_d;
  logic                tbl_we_q, tbl_we_d;
  logic                tbl_wdata_q, tbl_wdata_d;

  logic grant_ins, grant_lkp, hash_last;

  assign grant_ins = ins_req && (!lkp_req || !rr_q);
  assign grant_lkp = lkp_req && (!ins_req || rr_q);
  assign hash_last = (hcnt_q == HCNT_LAST);

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_cnt_q <= '0;
      hcnt_q    <= '0;
      is_lkp_q  <= 1'b0;
      rr_q      <= 1'b0;
      pfx_q     <= '0;
      cur_len_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      hcnt_q    <= hcnt_d;
      is_lkp_q  <= is_lkp_d;
      rr_q      <= rr_d;
      pfx_q     <= pfx_d;
      cur_len_q <= cur_len_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    hcnt_d    = hcnt_q;
    is_lkp_d  = is_lkp_q;
    rr_d      = rr_q;
    pfx_d     = pfx_q;
    cur_len_d = cur_len_q;
    unique case (state_q)
      S_CLEAR: begin
        if (clr_cnt_q == CLR_END) begin
          state_d   = S_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_ONE;
        end
      end
      S_IDLE: begin
        if (clr_req) begin
          // Address 0 is written on this very edge, so the count resumes at 1.
          state_d   = S_CLEAR;
          clr_cnt_d = CLR_ONE;
        end else if (grant_ins) begin
          state_d   = S_HASH;
          hcnt_d    = '0;
          is_lkp_d  = 1'b0;
          rr_d      = 1'b1;
          pfx_d     = ins_prefix;
          cur_len_d = ins_len;
        end else if (grant_lkp) begin
          state_d   = S_HASH;
          hcnt_d    = '0;
          is_lkp_d  = 1'b1;
          rr_d      = 1'b0;
          pfx_d     = lkp_prefix;
          cur_len_d = lkp_len;
        end
      end
      S_HASH: begin
        if (hash_last) state_d = is_lkp_q ? S_READ : S_WRITE;
        else           hcnt_d  = hcnt_q + 3'd1;
      end
      S_WRITE: state_d = S_IDLE;
      S_READ:  state_d = S_CHECK;
      S_CHECK: begin
        if (tbl_rdata || (cur_len_q == '0)) begin
          state_d = S_DONE;
        end else begin
          state_d   = S_HASH;
          hcnt_d    = '0;
          cur_len_d = cur_len_q - LEN_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_CLEAR;
    endcase
  end

  // Output logic: every output is a flop loaded with the value for the
  // cycle that follows this edge.
  always_comb begin
    ins_ack_d        = 1'b0;
    lkp_done_d       = 1'b0;
    tbl_we_d         = 1'b0;
    tbl_wdata_d      = 1'b0;
    lkp_hit_d        = lkp_hit_q;
    lkp_len_out_d    = lkp_len_out_q;
    lkp_prefix_out_d = lkp_prefix_out_q;
    clr_busy_d       = clr_busy_q;
    hash_prefix_d    = hash_prefix_q;
    hash_len_d       = hash_len_q;
    tbl_addr_d       = tbl_addr_q;
    unique case (state_q)
      S_CLEAR: begin
        if (clr_cnt_q == CLR_END) begin
          clr_busy_d = 1'b0;
        end else begin
          clr_busy_d = 1'b1;
          tbl_we_d   = 1'b1;
          tbl_addr_d = clr_cnt_q[ADDR_W-1:0];
        end
      end
      S_IDLE: begin
        if (clr_req) begin
          clr_busy_d = 1'b1;
          tbl_we_d   = 1'b1;
          tbl_addr_d = '0;
        end else if (grant_ins) begin
          hash_prefix_d = ins_prefix;
          hash_len_d    = ins_len;
        end else if (grant_lkp) begin
          hash_prefix_d = lkp_prefix;
          hash_len_d    = lkp_len;
        end
      end
      S_HASH: begin
        if (hash_last) begin
          tbl_addr_d = {cur_len_q, hash_value};
          if (!is_lkp_q) begin
            tbl_we_d    = 1'b1;
            tbl_wdata_d = 1'b1;
            ins_ack_d   = 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (tbl_rdata) begin
          lkp_done_d       = 1'b1;
          lkp_hit_d        = 1'b1;
          lkp_len_out_d    = cur_len_q;
          lkp_prefix_out_d = pfx_q;
        end else if (cur_len_q == '0) begin
          lkp_done_d       = 1'b1;
          lkp_hit_d        = 1'b0;
          lkp_len_out_d    = '0;
          lkp_prefix_out_d = pfx_q;
        end else begin
          hash_prefix_d = pfx_q;
          hash_len_d    = cur_len_q - LEN_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_ack_q        <= 1'b0;
      lkp_done_q       <= 1'b0;
      lkp_hit_q        <= 1'b0;
      lkp_len_out_q    <= '0;
      lkp_prefix_out_q <= '0;
      clr_busy_q       <= 1'b1;
      hash_prefix_q    <= '0;
      hash_len_q       <= '0;
      tbl_addr_q       <= '0;
      tbl_we_q         <= 1'b0;
      tbl_wdata_q      <= 1'b0;
    end else begin
      ins_ack_q        <= ins_ack_d;
      lkp_done_q       <= lkp_done_d;
      lkp_hit_q        <= lkp_hit_d;
      lkp_len_out_q    <= lkp_len_out_d;
      lkp_prefix_out_q <= lkp_prefix_out_d;
      clr_busy_q       <= clr_busy_d;
      hash_prefix_q    <= hash_prefix_d;
      hash_len_q       <= hash_len_d;
      tbl_addr_q       <= tbl_addr_d;
      tbl_we_q         <= tbl_we_d;
      tbl_wdata_q      <= tbl_wdata_d;
    end
  end

  assign ins_ack        = ins_ack_q;
  assign lkp_done       = lkp_done_q;
  assign lkp_hit        = lkp_hit_q;
  assign lkp_len_out    = lkp_len_out_q;
  assign lkp_prefix_out = lkp_prefix_out_q;
  assign clr_busy       = clr_busy_q;
  assign hash_prefix    = hash_prefix_q;
  assign hash_len       = hash_len_q;
  assign tbl_addr       = tbl_addr_q;
  assign tbl_we         = tbl_we_q;
  assign tbl_wdata      = tbl_wdata_q;

endmodule
